// File: rtl/gdp_pkg.sv
// Shared constants for the GDP block: flit type codes, FSM states, FIFO depths
// and almost-full thresholds.
package gdp_pkg;

  localparam int FLIT_W = 134;
  localparam int MD_W   = 256;
  localparam int PHV_W  = 1024;

  localparam int MD_DEPTH   = 2;
  localparam int PHV_DEPTH  = 2;
  localparam int DATA_DEPTH = 32;

  localparam int MD_ALF   = 2;
  localparam int PHV_ALF  = 2;
  localparam int DATA_ALF = 24;

  // Flit indices at or above this value are all treated as pass-through.
  localparam int K_SAT = 10;

  typedef enum logic [1:0] {
    FT_HEAD = 2'b01,
    FT_BODY = 2'b11,
    FT_TAIL = 2'b10
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [FLIT_W-1:0] flit;
  } data_entry_t;

  function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] f);
    return f[FLIT_W-1 -: 2];
  endfunction

endpackage

// File: rtl/gdp_fifo.sv
// Synchronous FIFO with registered empty/full/almost-full flags and a sticky
// overflow bit. A pop frees a slot for a push in the same cycle, even when full.
module gdp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int ALF   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             alf,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      alf      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
      alf   <= (count_nxt >= CW'(ALF));
      if (wr && !do_wr) overflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/gdp.sv
// GDP: merges buffered metadata and PHV back into the packet body on egress.
// Define GDP_PHV_WB_EN to also write the PHV back into flits 2..9.
module gdp
  import gdp_pkg::*;
#(
  parameter logic [7:0] LMID = 8'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MD_W-1:0]     in_gdp_md,
  input  logic                in_gdp_md_wr,
  output logic                out_gdp_md_alf,
  input  logic [PHV_W-1:0]    in_gdp_phv,
  input  logic                in_gdp_phv_wr,
  output logic                out_gdp_phv_alf,
  input  logic                in_gdp_data_wr,
  input  logic [FLIT_W-1:0]   in_gdp_data,
  input  logic                in_gdp_valid_wr,
  input  logic                in_gdp_valid,
  output logic                out_gdp_data_alf,
  output logic                pktout_data_wr,
  output logic [FLIT_W-1:0]   pktout_data,
  output logic                pktout_valid_wr,
  output logic                pktout_valid,
  input  logic                pktout_ready
);

  state_e            state;
  state_e            state_nxt;
  logic [3:0]        k;
  logic              md_rd, phv_rd, data_rd;
  logic              md_empty, phv_empty, data_empty;
  logic              md_full, phv_full, data_full;
  logic              md_ovf, phv_ovf, data_ovf;
  logic [MD_W-1:0]   md_head;
  logic [PHV_W-1:0]  phv_head;
  data_entry_t       data_in;
  data_entry_t       data_head;
  logic              is_head;
  logic              is_tail;
  logic [FLIT_W-1:0] flit_out;
  logic              unused_ok;

  gdp_fifo #(.WIDTH(MD_W), .DEPTH(MD_DEPTH), .ALF(MD_ALF)) u_md_fifo (
    .clk(clk), .rst(rst), .wr(in_gdp_md_wr), .din(in_gdp_md), .rd(md_rd),
    .dout(md_head), .empty(md_empty), .full(md_full), .alf(out_gdp_md_alf),
    .overflow(md_ovf)
  );

  gdp_fifo #(.WIDTH(PHV_W), .DEPTH(PHV_DEPTH), .ALF(PHV_ALF)) u_phv_fifo (
    .clk(clk), .rst(rst), .wr(in_gdp_phv_wr), .din(in_gdp_phv), .rd(phv_rd),
    .dout(phv_head), .empty(phv_empty), .full(phv_full), .alf(out_gdp_phv_alf),
    .overflow(phv_ovf)
  );

  // The valid bit only travels with the flit that carried in_gdp_valid_wr.
  assign data_in = '{valid: in_gdp_valid_wr & in_gdp_valid, flit: in_gdp_data};

  gdp_fifo #(.WIDTH($bits(data_entry_t)), .DEPTH(DATA_DEPTH), .ALF(DATA_ALF)) u_data_fifo (
    .clk(clk), .rst(rst), .wr(in_gdp_data_wr), .din(data_in), .rd(data_rd),
    .dout(data_head), .empty(data_empty), .full(data_full), .alf(out_gdp_data_alf),
    .overflow(data_ovf)
  );

  assign is_head = (flit_type(data_head.flit) == FT_HEAD);
  assign is_tail = (flit_type(data_head.flit) == FT_TAIL);

  always_comb begin
    state_nxt = state;
    data_rd   = 1'b0;
    md_rd     = 1'b0;
    phv_rd    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!data_empty) begin
          if (!is_head)                                       state_nxt = ST_DROP;
          else if (!md_empty && !phv_empty && pktout_ready)   state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pktout_ready && !data_empty) begin
          data_rd = 1'b1;
          if (is_tail) begin
            md_rd     = 1'b1;
            phv_rd    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        // MD/PHV stay queued: they belong to the next well-formed packet.
        if (!data_empty) begin
          data_rd = 1'b1;
          if (is_tail) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef GDP_PHV_WB_EN
  logic [2:0] phv_idx;
  // k=2 selects the top 128-bit slice of the PHV, k=9 the bottom one.
  assign phv_idx = 3'(4'd9 - k);
`endif

  always_comb begin
    flit_out = data_head.flit;
    if (k == 4'd0) begin
      flit_out[127:0] = md_head[127:0];
      if (md_head[87:80] == LMID) flit_out[87:80] = 8'd0;
    end else if (k == 4'd1) begin
      flit_out[127:0] = md_head[255:128];
    end
`ifdef GDP_PHV_WB_EN
    else if (k <= 4'd9) begin
      flit_out[127:0] = phv_head[phv_idx*128 +: 128];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      k               <= '0;
      pktout_data_wr  <= 1'b0;
      pktout_data     <= '0;
      pktout_valid_wr <= 1'b0;
      pktout_valid    <= 1'b0;
    end else begin
      state           <= state_nxt;
      pktout_data_wr  <= 1'b0;
      pktout_valid_wr <= 1'b0;
      pktout_valid    <= 1'b0;
      if (state == ST_SEND && data_rd) begin
        pktout_data_wr <= 1'b1;
        pktout_data    <= flit_out;
        if (is_tail) begin
          pktout_valid_wr <= 1'b1;
          pktout_valid    <= data_head.valid;
          k               <= '0;
        end else if (k != 4'(K_SAT)) begin
          k <= k + 4'd1;
        end
      end
    end
  end

  assign unused_ok = &{1'b0, md_full, phv_full, data_full, md_ovf, phv_ovf, data_ovf, phv_head};

endmodule
